// File: rtl/hit_resolver_pkg.sv
// Shared definitions for the fighting-game character FSM and the hit resolver.
// Contents: the 4-bit character state codes, the screen and sprite geometry
// constants, the round state type and the winner encoding.
package hit_resolver_pkg;

  typedef enum logic [3:0] {
    StIdle       = 4'd0,
    StLeft       = 4'd1,
    StRight      = 4'd2,
    StA1Startup  = 4'd3,
    StA1Active   = 4'd4,
    StA1Recovery = 4'd5,
    StA2Startup  = 4'd6,
    StA2Active   = 4'd7,
    StA2Recovery = 4'd8,
    StDamage     = 4'd9,
    StBlock      = 4'd10
  } char_state_e;

  localparam int unsigned CharWidth   = 128;
  localparam int unsigned ScreenWidth = 640;

  typedef enum logic {
    RndFight = 1'b0,
    RndKo    = 1'b1
  } round_e;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP1   = 2'b01;
  localparam logic [1:0] WinP2   = 2'b10;
  localparam logic [1:0] WinDraw = 2'b11;

endpackage

// File: rtl/hit_resolver_stun_counter.sv
// Stun counter: loads a frame count on a strobe, then counts down by one per
// frame until zero. A load while busy replaces the remaining count.
// Ports:
//   clk_game    game frame clock
//   reset       asynchronous, active-high
//   i_load      load strobe
//   i_load_val  frame count to load
//   o_busy      count is nonzero
module stun_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_game,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  output logic             o_busy
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_busy = (r_count != '0);

endmodule

// File: rtl/hit_resolver.sv
// Hit resolver: each frame decides whether an active attack connects, whether
// the defender blocks, and when the round ends. Tracks health, stun and the
// round result.
// Ports:
//   clk_game, reset           frame clock, asynchronous active-high reset
//   state_p1/p2, char1/2_x    character FSM state and left x per player
//   hit_p1/p2, block_p1/p2    one-frame event pulses
//   stun_p1/p2                player in hit or block stun
//   health_p1/p2              remaining health
//   game_over, winner         sticky round result
module hit_resolver
  import hit_resolver_pkg::*;
#(
  parameter int unsigned CHAR_WIDTH       = CharWidth,
  parameter int unsigned REACH_A1         = 32,
  parameter int unsigned REACH_A2         = 48,
  parameter int unsigned MAX_HEALTH       = 3,
  parameter int unsigned HITSTUN_FRAMES   = 12,
  parameter int unsigned BLOCKSTUN_FRAMES = 6
) (
  input  logic       clk_game,
  input  logic       reset,
  input  logic [3:0] state_p1,
  input  logic [3:0] state_p2,
  input  logic [9:0] char1_x,
  input  logic [9:0] char2_x,
  output logic       hit_p1,
  output logic       hit_p2,
  output logic       block_p1,
  output logic       block_p2,
  output logic       stun_p1,
  output logic       stun_p2,
  output logic [2:0] health_p1,
  output logic [2:0] health_p2,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int unsigned StunMax =
      (HITSTUN_FRAMES > BLOCKSTUN_FRAMES) ? HITSTUN_FRAMES : BLOCKSTUN_FRAMES;
  localparam int unsigned StunW = $clog2(StunMax + 1);

  round_e     r_round, w_round_nxt;
  logic [1:0] r_winner, w_winner_nxt;
  logic [2:0] r_health_p1, r_health_p2, w_health_p1_nxt, w_health_p2_nxt;
  logic       r_hit_done_p1, r_hit_done_p2, w_hit_done_p1_nxt, w_hit_done_p2_nxt;
  logic       r_hit_p1, r_hit_p2, r_block_p1, r_block_p2;

  logic        w_p1_left;
  logic [9:0]  w_left_x, w_right_x;
  logic [10:0] w_near, w_gap;
  logic        w_active_p1, w_active_p2;
  logic        w_connect_p1, w_connect_p2;
  logic        w_hit_p1, w_hit_p2, w_block_p1, w_block_p2;
  logic [StunW-1:0] w_stun_val_p1, w_stun_val_p2;

  // Geometry and event decode
  always_comb begin
    w_p1_left = (char1_x <= char2_x);
    w_left_x  = w_p1_left ? char1_x : char2_x;
    w_right_x = w_p1_left ? char2_x : char1_x;
    w_near    = {1'b0, w_left_x} + 11'(CHAR_WIDTH);
    w_gap     = ({1'b0, w_right_x} >= w_near) ? ({1'b0, w_right_x} - w_near) : 11'd0;

    w_active_p1 = (state_p1 == StA1Active) || (state_p1 == StA2Active);
    w_active_p2 = (state_p2 == StA1Active) || (state_p2 == StA2Active);

    // Connects are suppressed once the round is over.
    w_connect_p1 = (r_round == RndFight) && !r_hit_done_p1 &&
                   (((state_p1 == StA1Active) && (w_gap <= 11'(REACH_A1))) ||
                    ((state_p1 == StA2Active) && (w_gap <= 11'(REACH_A2))));
    w_connect_p2 = (r_round == RndFight) && !r_hit_done_p2 &&
                   (((state_p2 == StA1Active) && (w_gap <= 11'(REACH_A1))) ||
                    ((state_p2 == StA2Active) && (w_gap <= 11'(REACH_A2))));

    // Defender blocks when walking away from the attacker.
    w_block_p2 = w_connect_p1 && (w_p1_left ? (state_p2 == StRight) : (state_p2 == StLeft));
    w_hit_p2   = w_connect_p1 && !w_block_p2;
    w_block_p1 = w_connect_p2 && (w_p1_left ? (state_p1 == StLeft) : (state_p1 == StRight));
    w_hit_p1   = w_connect_p2 && !w_block_p1;

    // One event per active window; the latch drops once the attack leaves active.
    w_hit_done_p1_nxt = w_connect_p1 || (r_hit_done_p1 && w_active_p1);
    w_hit_done_p2_nxt = w_connect_p2 || (r_hit_done_p2 && w_active_p2);

    w_health_p1_nxt = (w_hit_p1 && (r_health_p1 != 3'd0)) ? r_health_p1 - 3'd1 : r_health_p1;
    w_health_p2_nxt = (w_hit_p2 && (r_health_p2 != 3'd0)) ? r_health_p2 - 3'd1 : r_health_p2;

    w_stun_val_p1 = w_hit_p1 ? StunW'(HITSTUN_FRAMES) : StunW'(BLOCKSTUN_FRAMES);
    w_stun_val_p2 = w_hit_p2 ? StunW'(HITSTUN_FRAMES) : StunW'(BLOCKSTUN_FRAMES);
  end

  // Round FSM next state
  always_comb begin
    w_round_nxt  = r_round;
    w_winner_nxt = r_winner;
    if (r_round == RndFight) begin
      if ((w_health_p1_nxt == 3'd0) && (w_health_p2_nxt == 3'd0)) begin
        w_round_nxt  = RndKo;
        w_winner_nxt = WinDraw;
      end else if (w_health_p2_nxt == 3'd0) begin
        w_round_nxt  = RndKo;
        w_winner_nxt = WinP1;
      end else if (w_health_p1_nxt == 3'd0) begin
        w_round_nxt  = RndKo;
        w_winner_nxt = WinP2;
      end
    end
  end

  always_ff @(posedge clk_game or posedge reset) begin
    if (reset) begin
      r_round       <= RndFight;
      r_winner      <= WinNone;
      r_health_p1   <= 3'(MAX_HEALTH);
      r_health_p2   <= 3'(MAX_HEALTH);
      r_hit_done_p1 <= 1'b0;
      r_hit_done_p2 <= 1'b0;
      r_hit_p1      <= 1'b0;
      r_hit_p2      <= 1'b0;
      r_block_p1    <= 1'b0;
      r_block_p2    <= 1'b0;
    end else begin
      r_round       <= w_round_nxt;
      r_winner      <= w_winner_nxt;
      r_health_p1   <= w_health_p1_nxt;
      r_health_p2   <= w_health_p2_nxt;
      r_hit_done_p1 <= w_hit_done_p1_nxt;
      r_hit_done_p2 <= w_hit_done_p2_nxt;
      r_hit_p1      <= w_hit_p1;
      r_hit_p2      <= w_hit_p2;
      r_block_p1    <= w_block_p1;
      r_block_p2    <= w_block_p2;
    end
  end

  stun_counter #(
    .Width (StunW)
  ) u_stun_p1 (
    .clk_game   (clk_game),
    .reset      (reset),
    .i_load     (w_hit_p1 || w_block_p1),
    .i_load_val (w_stun_val_p1),
    .o_busy     (stun_p1)
  );

  stun_counter #(
    .Width (StunW)
  ) u_stun_p2 (
    .clk_game   (clk_game),
    .reset      (reset),
    .i_load     (w_hit_p2 || w_block_p2),
    .i_load_val (w_stun_val_p2),
    .o_busy     (stun_p2)
  );

  assign hit_p1    = r_hit_p1;
  assign hit_p2    = r_hit_p2;
  assign block_p1  = r_block_p1;
  assign block_p2  = r_block_p2;
  assign health_p1 = r_health_p1;
  assign health_p2 = r_health_p2;
  assign game_over = (r_round == RndKo);
  assign winner    = r_winner;

endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver: a behavioural frame model pushes the
// expected outputs for every driven frame; they are popped and compared one
// frame later. Directed scenarios are followed by randomised frames.
module tb_hit_resolver;

  logic       clk_game = 1'b0;
  logic       reset    = 1'b0;
  logic [3:0] state_p1 = 4'd0;
  logic [3:0] state_p2 = 4'd0;
  logic [9:0] char1_x  = 10'd300;
  logic [9:0] char2_x  = 10'd450;
  logic       hit_p1, hit_p2, block_p1, block_p2, stun_p1, stun_p2, game_over;
  logic [2:0] health_p1, health_p2;
  logic [1:0] winner;

  hit_resolver u_dut (
    .clk_game  (clk_game),
    .reset     (reset),
    .state_p1  (state_p1),
    .state_p2  (state_p2),
    .char1_x   (char1_x),
    .char2_x   (char2_x),
    .hit_p1    (hit_p1),
    .hit_p2    (hit_p2),
    .block_p1  (block_p1),
    .block_p2  (block_p2),
    .stun_p1   (stun_p1),
    .stun_p2   (stun_p2),
    .health_p1 (health_p1),
    .health_p2 (health_p2),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk_game = ~clk_game;

  typedef struct packed {
    logic       hit1, hit2, blk1, blk2, stun1, stun2;
    logic [2:0] h1, h2;
    logic       go;
    logic [1:0] win;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural model state
  int m_h1, m_h2, m_stun1, m_stun2, m_win;
  bit m_done1, m_done2, m_ko;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit reach(input int s, input int gap);
    return ((s == 4) && (gap <= 32)) || ((s == 7) && (gap <= 48));
  endfunction

  task automatic model_reset();
    m_h1 = 3; m_h2 = 3; m_stun1 = 0; m_stun2 = 0; m_win = 0;
    m_done1 = 0; m_done2 = 0; m_ko = 0;
    sb_q.delete();
  endtask

  task automatic model_push(input int s1, input int s2, input int x1, input int x2);
    int   left, right, gap;
    bit   p1l, c1, c2, b1, b2, h1, h2;
    exp_t e;
    p1l   = (x1 <= x2);
    left  = p1l ? x1 : x2;
    right = p1l ? x2 : x1;
    gap   = (right >= left + 128) ? right - (left + 128) : 0;
    c1 = !m_ko && !m_done1 && reach(s1, gap);
    c2 = !m_ko && !m_done2 && reach(s2, gap);
    b2 = c1 && (p1l ? (s2 == 2) : (s2 == 1));
    b1 = c2 && (p1l ? (s1 == 1) : (s1 == 2));
    h2 = c1 && !b2;
    h1 = c2 && !b1;
    m_done1 = c1 || (m_done1 && (s1 == 4 || s1 == 7));
    m_done2 = c2 || (m_done2 && (s2 == 4 || s2 == 7));
    if (h1) m_stun1 = 12; else if (b1) m_stun1 = 6; else if (m_stun1 > 0) m_stun1--;
    if (h2) m_stun2 = 12; else if (b2) m_stun2 = 6; else if (m_stun2 > 0) m_stun2--;
    if (h1 && m_h1 > 0) m_h1--;
    if (h2 && m_h2 > 0) m_h2--;
    if (!m_ko && (m_h1 == 0 || m_h2 == 0)) begin
      m_ko  = 1;
      m_win = (m_h1 == 0 && m_h2 == 0) ? 3 : (m_h2 == 0) ? 1 : 2;
    end
    e.hit1 = h1; e.hit2 = h2; e.blk1 = b1; e.blk2 = b2;
    e.stun1 = (m_stun1 != 0); e.stun2 = (m_stun2 != 0);
    e.h1 = 3'(m_h1); e.h2 = 3'(m_h2); e.go = m_ko; e.win = 2'(m_win);
    sb_q.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_eq("hit_p1", 32'(hit_p1), 32'(e.hit1));
    check_eq("hit_p2", 32'(hit_p2), 32'(e.hit2));
    check_eq("block_p1", 32'(block_p1), 32'(e.blk1));
    check_eq("block_p2", 32'(block_p2), 32'(e.blk2));
    check_eq("stun_p1", 32'(stun_p1), 32'(e.stun1));
    check_eq("stun_p2", 32'(stun_p2), 32'(e.stun2));
    check_eq("health_p1", 32'(health_p1), 32'(e.h1));
    check_eq("health_p2", 32'(health_p2), 32'(e.h2));
    check_eq("game_over", 32'(game_over), 32'(e.go));
    check_eq("winner", 32'(winner), 32'(e.win));
  endtask

  // One frame: drive on the falling edge, compare just after the rising edge.
  task automatic frame(input logic [3:0] s1, input logic [3:0] s2,
                       input logic [9:0] x1, input logic [9:0] x2);
    @(negedge clk_game);
    state_p1 = s1; state_p2 = s2; char1_x = x1; char2_x = x2;
    model_push(int'(s1), int'(s2), int'(x1), int'(x2));
    @(posedge clk_game);
    #1;
    compare_out();
  endtask

  // Asynchronous reset applied between clock edges; outputs checked before any edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_eq({tag, "_stun"}, 32'({stun_p1, stun_p2}), 32'd0);
    check_eq({tag, "_pulses"}, 32'({hit_p1, hit_p2, block_p1, block_p2}), 32'd0);
    check_eq({tag, "_health"}, 32'({health_p1, health_p2}), 32'({3'd3, 3'd3}));
    check_eq({tag, "_over"}, 32'({game_over, winner}), 32'd0);
    model_reset();
    state_p1 = 4'd0; state_p2 = 4'd0;
    @(negedge clk_game);
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input logic [9:0] x1, input logic [9:0] x2);
    for (int i = 0; i < n; i++) frame(4'd0, 4'd0, x1, x2);
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // Hit in range, attack held 3 frames: one pulse, 12 frames of stun.
    for (int i = 0; i < 3; i++) frame(4'd4, 4'd0, 10'd300, 10'd450);
    idle(12, 10'd300, 10'd450);
    check_eq("hit_health_p2", 32'(health_p2), 32'd2);
    check_eq("hit_stun_over", 32'(stun_p2), 32'd0);

    // Block by walking away.
    do_reset("reset_blk");
    for (int i = 0; i < 3; i++) frame(4'd4, 4'd2, 10'd300, 10'd450);
    check_eq("blk_health_p2", 32'(health_p2), 32'd3);
    idle(5, 10'd300, 10'd450);

    // Out of range, then in range for A2.
    do_reset("reset_rng");
    for (int i = 0; i < 3; i++) frame(4'd7, 4'd0, 10'd300, 10'd500);
    frame(4'd7, 4'd0, 10'd300, 10'd470);
    check_eq("rng_hit_p2", 32'(hit_p2), 32'd1);
    idle(2, 10'd300, 10'd470);

    // Trade.
    do_reset("reset_trade");
    frame(4'd4, 4'd7, 10'd300, 10'd440);
    check_eq("trade_hits", 32'({hit_p1, hit_p2}), 32'd3);
    check_eq("trade_health", 32'({health_p1, health_p2}), 32'({3'd2, 3'd2}));
    idle(2, 10'd300, 10'd440);

    // KO by three hits, then a further attack is ignored.
    do_reset("reset_ko");
    for (int i = 0; i < 3; i++) begin
      frame(4'd4, 4'd0, 10'd300, 10'd450);
      frame(4'd0, 4'd0, 10'd300, 10'd450);
    end
    check_eq("ko_result", 32'({game_over, winner, health_p2}), 32'({1'b1, 2'b01, 3'd0}));
    frame(4'd4, 4'd0, 10'd300, 10'd450);
    check_eq("ko_no_pulse", 32'(hit_p2), 32'd0);
    idle(12, 10'd300, 10'd450);

    // Draw by trading down to zero.
    do_reset("reset_draw");
    for (int i = 0; i < 3; i++) begin
      frame(4'd4, 4'd7, 10'd300, 10'd440);
      frame(4'd0, 4'd0, 10'd300, 10'd440);
    end
    check_eq("draw_winner", 32'({game_over, winner}), 32'({1'b1, 2'b11}));

    // Reset mid-stun with 5 frames remaining.
    do_reset("reset_stun_pre");
    frame(4'd4, 4'd0, 10'd300, 10'd450);
    idle(7, 10'd300, 10'd450);
    check_eq("stun_before_reset", 32'(stun_p2), 32'd1);
    do_reset("reset_mid_stun");

    // Randomised frames, including mirrored positions and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [9:0] xa, xb;
      if ($urandom_range(0, 39) == 0) do_reset("reset_rand");
      xa = 10'($urandom_range(250, 330));
      xb = 10'($urandom_range(380, 500));
      if ($urandom_range(0, 3) == 0)
        frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), xb, xa);
      else
        frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), xa, xb);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
